// File: rtl/dft_twiddle_seq_if.sv
// Bus bundle for the DFT twiddle-address sequencer.
// Optional inverse-sweep select (inv) exists only when DFT_SEQ_INVERSE_EN is defined.
interface dft_twiddle_seq_if #(
    parameter int unsigned ADDR_W = 2
) ();
    logic              start;
    logic [ADDR_W-1:0] k_first;
    logic [ADDR_W-1:0] k_last;
    logic              hold;
`ifdef DFT_SEQ_INVERSE_EN
    logic              inv;
`endif
    logic [ADDR_W-1:0] raddr;
    logic              rd;
    logic [ADDR_W-1:0] smp_addr;
    logic [ADDR_W-1:0] cur_k;
    logic              vld;
    logic              last;
    logic              busy;
    logic              done;

`ifdef DFT_SEQ_INVERSE_EN
    modport master (
        output start, k_first, k_last, hold, inv,
        input  raddr, rd, smp_addr, cur_k, vld, last, busy, done
    );
    modport slave (
        input  start, k_first, k_last, hold, inv,
        output raddr, rd, smp_addr, cur_k, vld, last, busy, done
    );
`else
    modport master (
        output start, k_first, k_last, hold,
        input  raddr, rd, smp_addr, cur_k, vld, last, busy, done
    );
    modport slave (
        input  start, k_first, k_last, hold,
        output raddr, rd, smp_addr, cur_k, vld, last, busy, done
    );
`endif
endinterface

// File: rtl/dft_twiddle_seq.sv
// Sweeps DFT bins k_first..k_last, issuing twiddle ROM reads at (k*n) mod N via a phase accumulator.
// Define DFT_SEQ_INVERSE_EN to add the inv input (accumulator steps by N-k for the inverse DFT).
module dft_twiddle_seq #(
    parameter int unsigned ADDR_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    dft_twiddle_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] acc_q;
    logic [ADDR_W-1:0] k_q;
    logic [ADDR_W-1:0] k_end_q;
    logic              rd_q;
    logic              vld_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;
`ifdef DFT_SEQ_INVERSE_EN
    logic              inv_q;
`endif

    logic [ADDR_W-1:0] step_c;
    logic              n_wrap_c;
    logic              last_bin_c;

    // Phase increment per sample: +k forward, -k (mod N) inverse
    always_comb begin
        step_c = k_q;
`ifdef DFT_SEQ_INVERSE_EN
        if (inv_q) step_c = ADDR_W'(0) - k_q;
`endif
    end

    assign n_wrap_c   = &n_q;
    assign last_bin_c = (k_q == k_end_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            k_end_q <= '0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DFT_SEQ_INVERSE_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            // ROM latency is one cycle: vld/last trail the read that was presented
            vld_q  <= rd_q;
            last_q <= rd_q & n_wrap_c;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        n_q     <= '0;
                        acc_q   <= '0;
                        k_q     <= bus.k_first;
                        k_end_q <= (bus.k_first > bus.k_last) ? bus.k_first : bus.k_last;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef DFT_SEQ_INVERSE_EN
                        inv_q   <= bus.inv;
`endif
                    end
                end
                RUN: begin
                    if (rd_q && n_wrap_c && last_bin_c) begin
                        state <= FLUSH;
                        rd_q  <= 1'b0;
                    end else begin
                        rd_q <= ~bus.hold;
                        if (rd_q) begin
                            if (n_wrap_c) begin
                                n_q   <= '0;
                                acc_q <= '0;
                                k_q   <= k_q + ADDR_W'(1);
                            end else begin
                                n_q   <= n_q + ADDR_W'(1);
                                acc_q <= acc_q + step_c;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.raddr    = acc_q;
    assign bus.rd       = rd_q;
    assign bus.smp_addr = n_q;
    assign bus.cur_k    = k_q;
    assign bus.vld      = vld_q;
    assign bus.last     = last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_dft_twiddle_seq.sv
// Self-checking bench for dft_twiddle_seq: vector table of sweeps plus reset/abort sequence.
// Define DFT_SEQ_INVERSE_EN to also exercise the inverse sweep.
module tb_dft_twiddle_seq;
    localparam int unsigned ADDR_W = 2;
    localparam int          N      = 4;

    logic tb_clk = 1'b0;
    logic rst_n;
    always #5 tb_clk = ~tb_clk;

    dft_twiddle_seq_if #(.ADDR_W(ADDR_W)) bus ();
    dft_twiddle_seq #(.ADDR_W(ADDR_W)) dut (.clk(tb_clk), .rst_n(rst_n), .bus(bus));

    typedef struct {int raddr; int smp; int k; bit last;} exp_t;
    typedef struct {int kf; int kl; int hold_at; int hold_len; int inv; int exp_done;} vec_t;

    exp_t q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   exp_vld  = 1'b0;
    bit   exp_last = 1'b0;

    function automatic int outs_packed();
        return int'({bus.raddr, bus.rd, bus.smp_addr, bus.cur_k,
                     bus.vld, bus.last, bus.busy, bus.done});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference sweep: raddr from an explicit product, independent of any accumulator
    task automatic push_sweep(input int kf, input int kl, input int inv);
        int ke = (kf > kl) ? kf : kl;
        for (int k = kf; k <= ke; k++)
            for (int n = 0; n < N; n++) begin
                int r = (k * n) % N;
                if (inv != 0) r = (N - r) % N;
                q.push_back('{r, n, k, (n == N - 1)});
            end
    endtask

    // Per-cycle monitor, called just after each falling edge
    task automatic mon_cycle();
        exp_t e;
        chk("vld", int'(bus.vld), int'(exp_vld));
        chk("last", int'(bus.last), int'(exp_last));
        if (bus.rd) begin
            if (q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
                exp_vld = 1'b1; exp_last = 1'b0;
            end else begin
                e = q.pop_front();
                chk("raddr", int'(bus.raddr), e.raddr);
                chk("smp_addr", int'(bus.smp_addr), e.smp);
                chk("cur_k", int'(bus.cur_k), e.k);
                exp_vld = 1'b1; exp_last = e.last;
            end
        end else begin
            exp_vld = 1'b0; exp_last = 1'b0;
        end
    endtask

    task automatic run_sweep(input int kf, input int kl, input int hold_at,
                             input int hold_len, input int inv, input int exp_done);
        int reads = 0;
        int hold_left = 0;
        int done_cyc = 0;
        push_sweep(kf, kl, inv);
        bus.start   = 1'b1;
        bus.k_first = ADDR_W'(kf);
        bus.k_last  = ADDR_W'(kl);
`ifdef DFT_SEQ_INVERSE_EN
        bus.inv     = 1'(inv);
`endif
        @(negedge tb_clk);
        bus.start = 1'b0;
        chk("busy_run", int'(bus.busy), 1);
        for (int cyc = 1; cyc <= 64; cyc++) begin
            mon_cycle();
            if (bus.rd) begin
                reads++;
                if (reads == hold_at) hold_left = hold_len;
            end
            bus.hold = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge tb_clk);
        end
        bus.hold = 1'b0;
        chk("done_cycle", done_cyc, exp_done);
        chk("queue_empty", q.size(), 0);
        q.delete();
        @(negedge tb_clk);
        mon_cycle();
        chk("done_single", int'(bus.done), 0);
        chk("busy_idle", int'(bus.busy), 0);
    endtask

    initial begin
        // {k_first, k_last, hold after read #, hold cycles, inv, done cycle after start}
        vecs[0] = '{1, 1, 0, 0, 0, 6};
        vecs[1] = '{3, 3, 0, 0, 0, 6};
        vecs[2] = '{1, 2, 0, 0, 0, 10};
        vecs[3] = '{1, 1, 2, 2, 0, 8};
        vecs[4] = '{2, 1, 0, 0, 0, 6};
        vecs[5] = '{0, 3, 0, 0, 0, 18};
        vecs[6] = '{3, 3, 4, 1, 0, 6};
        vecs[7] = '{0, 0, 1, 3, 0, 9};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.hold = 1'b0; bus.k_first = '0; bus.k_last = '0;
`ifdef DFT_SEQ_INVERSE_EN
        bus.inv = 1'b0;
`endif
        @(negedge tb_clk);
        chk("reset_outs", outs_packed(), 0);
        @(negedge tb_clk);
        rst_n = 1'b1;
        @(negedge tb_clk);

        for (int i = 0; i < 8; i++)
            run_sweep(vecs[i].kf, vecs[i].kl, vecs[i].hold_at, vecs[i].hold_len,
                      vecs[i].inv, vecs[i].exp_done);

`ifdef DFT_SEQ_INVERSE_EN
        run_sweep(1, 1, 0, 0, 1, 6);
        run_sweep(3, 3, 0, 0, 1, 6);
`endif

        // Start while busy is ignored, then reset aborts the sweep without done
        push_sweep(0, 3, 0);
        bus.start = 1'b1; bus.k_first = ADDR_W'(0); bus.k_last = ADDR_W'(3);
        @(negedge tb_clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            mon_cycle();
            chk("no_done_mid", int'(bus.done), 0);
            bus.start = (cyc == 3);
            bus.k_first = ADDR_W'(3); bus.k_last = ADDR_W'(3);
            @(negedge tb_clk);
        end
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", outs_packed(), 0);
        q.delete();
        exp_vld = 1'b0; exp_last = 1'b0;
        repeat (2) begin
            @(negedge tb_clk);
            chk("rst_hold_outs", outs_packed(), 0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge tb_clk);
            chk("idle_after_rst", outs_packed(), 0);
        end

        run_sweep(1, 2, 0, 0, 0, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dft_twiddle_seq.md
DFT_TWIDDLE_SEQ -- requirements
Module: dft_twiddle_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, giving log2 of the DFT length N (N = 2**ADDR_W).
REQ-002 The block SHALL use one clock, clk; its reset is asynchronous and active-low.
REQ-003 Port clk: input, 1 bit; system clock, all state updates on its rising edge.
REQ-004 Port rst_n: input, 1 bit; asynchronous active-low reset.
REQ-005 Port start: input, 1 bit; one-cycle request to begin a sweep, honoured only in IDLE.
REQ-006 Port k_first: input, ADDR_W bits; first bin of the sweep, sampled on an accepted start.
REQ-007 Port k_last: input, ADDR_W bits; last bin of the sweep, sampled on an accepted start.
REQ-008 Port hold: input, 1 bit; back-pressure that stalls the sweep while high.
REQ-009 Port raddr: output, ADDR_W bits; twiddle ROM read address.
REQ-010 Port rd: output, 1 bit; twiddle ROM read strobe.
REQ-011 Port smp_addr: output, ADDR_W bits; sample index n, aligned with raddr.
REQ-012 Port cur_k: output, ADDR_W bits; bin being processed, aligned with raddr.
REQ-013 Port vld: output, 1 bit; ROM data valid, equal to rd delayed by one cycle (ROM read latency 1).
REQ-014 Port last: output, 1 bit; high with vld for the n = N-1 read of each bin.
REQ-015 Port busy: output, 1 bit; high in every state except IDLE.
REQ-016 Port done: output, 1 bit; one-cycle pulse when the sweep completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-018 Transitions:
- IDLE to RUN on start.
- RUN to FLUSH after issuing n = N-1 of bin k_last.
- FLUSH to DONE after one cycle.
- DONE to IDLE after one cycle.
REQ-019 On an accepted start, the first RUN cycle SHALL present rd=1, raddr=0, smp_addr=0 and cur_k=k_first.
REQ-020 In RUN with hold=0, each cycle SHALL issue one read, then advance n by 1 and advance the phase raddr by cur_k, modulo N.
REQ-021 raddr SHALL always equal (cur_k*n) mod N, produced by a wrapping ADDR_W-bit accumulator with no multiplier.
REQ-022 After n = N-1, the next cycle SHALL set n=0, raddr=0 and cur_k=cur_k+1, with no idle gap between bins.
REQ-023 While hold=1 in RUN, rd SHALL be 0 and n, raddr and cur_k SHALL be frozen.
REQ-024 hold SHALL have no effect in any state other than RUN.
REQ-025 done SHALL pulse in the DONE state, which is the cycle after the final vld.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 If k_first > k_last, only bin k_first SHALL be swept.
REQ-028 rd SHALL be 0 outside RUN.
REQ-029 vld and last SHALL be 0 except in the cycle after a read.

Reset
REQ-030 While rst_n=0, the FSM SHALL be in IDLE and every output SHALL be 0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep immediately, with no done pulse; a new start is required afterwards.

Configuration
REQ-032 When macro DFT_SEQ_INVERSE_EN is defined, the block SHALL add a 1-bit input inv, sampled on start.
REQ-033 With DFT_SEQ_INVERSE_EN defined and inv=1, raddr SHALL be (-(cur_k*n)) mod N, i.e. the accumulator steps by N-cur_k.
REQ-034 Without DFT_SEQ_INVERSE_EN, port inv SHALL NOT exist and the sweep SHALL always be forward.

Verification
REQ-035 Scenario: ADDR_W=2, start with k_first=k_last=1 -> raddr sequence 0,1,2,3 on consecutive rd cycles; vld each following cycle; last with the 4th vld; done one cycle later.
REQ-036 Scenario: k_first=k_last=3 -> raddr sequence 0,3,2,1 (wrap-around).
REQ-037 Scenario: k_first=1, k_last=2 -> raddr 0,1,2,3,0,2,0,2 with cur_k 1,1,1,1,2,2,2,2, no gap between bins; last asserted twice; done asserted once.
REQ-038 Scenario: hold=1 for 2 cycles after the second read of k=1 -> rd=0 for those 2 cycles, the sequence then resumes at raddr=2, and done is delayed by 2 cycles.
REQ-039 Scenario: start pulsed while busy, then rst_n pulsed low mid-sweep -> the second start is ignored; outputs are 0 during reset; no done pulse; a fresh start after reset runs normally.
REQ-040 Scenario: with DFT_SEQ_INVERSE_EN defined, inv=1 and k=1 -> raddr sequence 0,3,2,1.
